// File: rtl/vgac_param.sv
// Parametrised VGA timing controller: programmable timing and sync polarity,
// scaled frame-buffer addressing, and read-latency-compensated pixel/sync output.
module vgac_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 4,
    parameter int RD_LAT   = 1,
    parameter int SCALE    = 0,
    parameter int ROW_W    = 9,
    parameter int COL_W    = 10
) (
    input  logic              vga_clk,
    input  logic              clrn,
    input  logic [3*CW-1:0]   d_in,
    output logic [ROW_W-1:0]  row_addr,
    output logic [COL_W-1:0]  col_addr,
    output logic              rdn,
    output logic [CW-1:0]     r,
    output logic [CW-1:0]     g,
    output logic [CW-1:0]     b,
    output logic              hs,
    output logic              vs,
    output logic              line_start,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare count of headroom so the sync-end bound is representable even with no back porch.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    typedef struct packed {
        logic vis;
        logic hsync;
        logic vsync;
        logic line_first;
        logic frame_first;
    } flags_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    flags_t        cur;
    flags_t        pipe [0:RD_LAT];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // NOTE: default the whole struct first so no field can infer a latch.
    always_comb begin
        cur             = '0;
        cur.vis         = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        cur.hsync       = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        cur.vsync       = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        cur.line_first  = (h_cnt == '0) && (v_cnt < V_VIS_END);
        cur.frame_first = (h_cnt == '0) && (v_cnt == '0);
    end

    // Stage A: frame-buffer address and read strobe; address holds through blanking.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            row_addr <= '0;
            col_addr <= '0;
            rdn      <= 1'b1;
        end else begin
            rdn <= !cur.vis;
            if (cur.vis) begin
                col_addr <= COL_W'(h_cnt >> SCALE);
                row_addr <= ROW_W'(v_cnt >> SCALE);
            end
        end
    end

    // NOTE: this flag pipeline is reset, unlike a data RAM, so no stale sync
    // or start pulse can leak out after clrn.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Output stage: pipe[RD_LAT] lines up with d_in for the same pixel.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            hs          <= ~HS_ACT;
            vs          <= ~VS_ACT;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (pipe[RD_LAT].vis) begin
                r <= d_in[3*CW-1 -: CW];
                g <= d_in[2*CW-1 -: CW];
                b <= d_in[CW-1:0];
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
            hs          <= pipe[RD_LAT].hsync ? HS_ACT : ~HS_ACT;
            vs          <= pipe[RD_LAT].vsync ? VS_ACT : ~VS_ACT;
            line_start  <= pipe[RD_LAT].line_first;
            frame_start <= pipe[RD_LAT].frame_first;
        end
    end

endmodule
